// File: rtl/contador_pkg.sv
// Shared definitions for the push-button counter controller: FSM state
// encoding, debounce counter width and the press-action decision.
package contador_pkg;

    // Width of the debounce counter; wide enough for DEBOUNCE_CYCLES up to 2^20.
    localparam int DBCNT_W = 20;

    // Largest debounce length the counter can express (terminal value 2^20-1).
    localparam int DEBOUNCE_MAX = 1 << DBCNT_W;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } estado_t;

    // What an accepted press does to the downstream counter.
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_INC  = 2'd1,
        ACC_CLR  = 2'd2
    } accion_t;

    // A disabled press does nothing.  At or beyond the terminal count the press
    // clears the counter instead of incrementing, so an 8-bit counter with
    // limite=255 wraps by clearing and never overflows through an increment.
    function automatic accion_t decide_accion(input logic       habilita,
                                              input logic [7:0] conta,
                                              input logic [7:0] limite);
        accion_t acc;
        acc = ACC_NONE;
        if (habilita) begin
            if (conta >= limite) begin
                acc = ACC_CLR;
            end else begin
                acc = ACC_INC;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer bringing the raw push-button level into the clk domain.
module sincronizador (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/control_contador.sv
// Push-button controller for a downstream 8-bit counter.  The button is
// synchronized and debounced; each accepted press produces a single registered
// pulse: inc_o to advance the counter, or clr_o+tope_o when the count has
// reached the limit.  At integration, inc_o drives the counter's button/enable
// input and (clr_o | reset_i) drives the counter's synchronous reset.
module control_contador
    import contador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       boton_i,
    input  logic       habilita_i,
    input  logic [7:0] limite_i,
    input  logic [7:0] conta_i,
    output logic       inc_o,
    output logic       clr_o,
    output logic       tope_o,
    output logic       presionado_o
);

    // Reject debounce lengths the counter cannot represent.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : g_bad_debounce
        $error("control_contador: DEBOUNCE_CYCLES out of range 2..2^20");
    end

    // Terminal debounce count: the level has been stable for DEBOUNCE_CYCLES cycles.
    localparam logic [DBCNT_W-1:0] DB_LAST = DBCNT_W'(DEBOUNCE_CYCLES - 1);

    logic               s;
    estado_t            estado;
    estado_t            estado_sig;
    logic [DBCNT_W-1:0] dbcnt;
    logic [DBCNT_W-1:0] dbcnt_sig;
    logic               inc_sig;
    logic               clr_sig;
    logic               tope_sig;
    accion_t            accion;

    sincronizador u_sincronizador (
        .clk   (clk),
        .reset (reset_i),
        .d     (boton_i),
        .q     (s)
    );

    // The action is decided from the inputs present on the accepting cycle only.
    assign accion = decide_accion(habilita_i, conta_i, limite_i);

    // State, debounce counter and action pulses; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            estado <= IDLE;
            dbcnt  <= '0;
            inc_o  <= 1'b0;
            clr_o  <= 1'b0;
            tope_o <= 1'b0;
        end else begin
            estado <= estado_sig;
            dbcnt  <= dbcnt_sig;
            inc_o  <= inc_sig;
            clr_o  <= clr_sig;
            tope_o <= tope_sig;
        end
    end

    // Next state and pulse requests; an action fires only on DB_PRESS -> PRESSED.
    always_comb begin
        estado_sig = estado;
        dbcnt_sig  = dbcnt;
        inc_sig    = 1'b0;
        clr_sig    = 1'b0;
        tope_sig   = 1'b0;
        case (estado)
            IDLE: begin
                if (s) begin
                    estado_sig = DB_PRESS;
                    dbcnt_sig  = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    estado_sig = IDLE;
                end else if (dbcnt == DB_LAST) begin
                    estado_sig = PRESSED;
                    case (accion)
                        ACC_INC: inc_sig = 1'b1;
                        ACC_CLR: begin
                            clr_sig  = 1'b1;
                            tope_sig = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    dbcnt_sig = dbcnt + DBCNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    estado_sig = DB_RELEASE;
                    dbcnt_sig  = '0;
                end
            end
            DB_RELEASE: begin
                if (s) begin
                    estado_sig = PRESSED;
                end else if (dbcnt == DB_LAST) begin
                    estado_sig = IDLE;
                end else begin
                    dbcnt_sig = dbcnt + DBCNT_W'(1);
                end
            end
            default: begin
                estado_sig = IDLE;
                dbcnt_sig  = '0;
            end
        endcase
    end

    assign presionado_o = (estado == PRESSED) || (estado == DB_RELEASE);

endmodule

// File: doc/control_contador.md
CONTROL_CONTADOR -- requirements
Module: control_contador

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, cycles boton_i must stay stable to count as a press or a release; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port boton_i, input, 1, raw asynchronous push-button level.
REQ-005 SHALL have port habilita_i, input, 1, action enable; when low, presses are debounced but produce no action.
REQ-006 SHALL have port limite_i, input, 8, terminal count value for the downstream 8-bit counter.
REQ-007 SHALL have port conta_i, input, 8, current count fed back from the downstream counter.
REQ-008 SHALL have port inc_o, output, 1, one-cycle increment pulse to the counter's button/enable input.
REQ-009 SHALL have port clr_o, output, 1, one-cycle clear pulse to the counter's synchronous reset.
REQ-010 SHALL have port tope_o, output, 1, one-cycle pulse flagging wrap at limit.
REQ-011 SHALL have port presionado_o, output, 1, debounced button level (high in PRESSED and DB_RELEASE).

Function
REQ-012 SHALL pass boton_i through a 2-flop synchronizer; s denotes the second flop's output.
REQ-013 SHALL implement FSM states IDLE, DB_PRESS, PRESSED, DB_RELEASE plus a 20-bit debounce counter dbcnt.
REQ-014 IDLE: s=1 -> DB_PRESS, dbcnt<=0; else stay.
REQ-015 DB_PRESS: s=0 -> IDLE (glitch rejected, no action); s=1 and dbcnt<DEBOUNCE_CYCLES-1 -> dbcnt+1; s=1 and dbcnt==DEBOUNCE_CYCLES-1 -> PRESSED and fire one action.
REQ-016 PRESSED: s=0 -> DB_RELEASE, dbcnt<=0; else stay; holding the button SHALL never generate further actions.
REQ-017 DB_RELEASE: s=1 -> PRESSED (no action); s=0 and dbcnt==DEBOUNCE_CYCLES-1 -> IDLE; else dbcnt+1.
REQ-018 Action, evaluated on the transition cycle: habilita_i=0 -> none; conta_i>=limite_i (unsigned) -> clr_o=1 and tope_o=1; otherwise inc_o=1.
REQ-019 inc_o and clr_o SHALL be mutually exclusive, registered, and high for exactly one cycle per accepted press.
REQ-020 With boton_i held high from edge 0, the action pulse SHALL be visible after edge DEBOUNCE_CYCLES+2 (latency DEBOUNCE_CYCLES+3 edges).
REQ-021 limite_i=0 SHALL make every enabled press a clear; limite_i=255 SHALL make conta_i=255 clear, never overflow via inc.
REQ-022 conta_i and limite_i are sampled only on the action cycle; changes at other times SHALL have no effect.

Reset
REQ-023 reset_i=1 at a clock edge SHALL set state IDLE, dbcnt 0, synchronizer flops 0, inc_o/clr_o/tope_o/presionado_o 0, in that same cycle.
REQ-024 Reset asserted mid-debounce or in PRESSED SHALL abort with no action; a button still held after reset SHALL re-debounce from IDLE and produce exactly one action.
REQ-025 Reset SHALL take priority over every FSM transition and output pulse.

Structure
REQ-026 State enum type estado_t and the dbcnt width constant SHALL live in shared package contador_pkg.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module named sincronizador, reset by reset_i.
REQ-028 Top-level integration SHALL wire inc_o to the counter's button input and clr_o OR system reset to the counter's reset.

Verification (DEBOUNCE_CYCLES=4 for all)
REQ-029 Reset, boton_i high from edge 0 held 20 cycles, habilita_i=1, limite_i=10, conta_i=3 -> single inc_o pulse after edge 6, none after, presionado_o high from edge 6.
REQ-030 boton_i high for 3 cycles then low -> no inc_o/clr_o, FSM back to IDLE, presionado_o stays 0.
REQ-031 Press with conta_i=10, limite_i=10 -> clr_o and tope_o pulse together one cycle, inc_o stays 0; repeat with limite_i=0, conta_i=0 -> clr_o.
REQ-032 Release bounce: during DB_RELEASE toggle boton_i low 2 cycles/high 2 cycles, then re-press after full release -> exactly two actions total.
REQ-033 reset_i pulsed one cycle at dbcnt=2 of DB_PRESS with boton_i held -> no action before reset, one inc_o after edge 6 counted from reset release.
REQ-034 habilita_i=0 during a full press/release -> no pulses, presionado_o still follows debounced level.
